fetch_stage: RTL and testbench

Instruction-fetch stage of the RISC core. It owns the program counter, drives the word address into instruction memory, and captures the returned instruction into the IF/ID pipeline register for the decode stage. Decode and execute can stall it or redirect it to a new PC. It replaces the bare PC register as the sole producer of instruction-memory addresses.

---
 rtl/risc_pkg.sv | 19 +
 rtl/fetch_next_pc.sv | 45 ++++
 rtl/fetch_stage.sv | 75 +++++++
 tb/tb_fetch_stage.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared RISC core definitions: widths, the NOP encoding, opcode field bounds
// and the fetch-stage state encoding.
package risc_pkg;

    localparam int PC_W    = 5;
    localparam int INSTR_W = 32;

    localparam logic [31:0] NOP = 32'h0000_0000;

    localparam int          OPC_HI = 31;
    localparam int          OPC_LO = 26;
    localparam logic [5:0]  OPC_J  = 6'b000010;

    typedef enum logic {
        RESET_HOLD = 1'b0,
        RUN        = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC select for the fetch stage.
// Optional J predecode is enabled by defining FETCH_JUMP_PREDECODE_EN.
module fetch_next_pc #(
    parameter int              PC_W     = 5,
    parameter int              INSTR_W  = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               reset,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               stall,
    input  logic               in_run,
    input  logic [INSTR_W-1:0] instr,
    input  logic [PC_W-1:0]    pc,
    input  logic [PC_W-1:0]    pc_plus1,
    output logic [PC_W-1:0]    next_pc,
    output logic               take_jump
);
    import risc_pkg::*;

    // Only the opcode and low target bits matter; the rest of the word is
    // deliberately ignored here.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{in_run, instr};

    always_comb begin
        take_jump = 1'b0;
`ifdef FETCH_JUMP_PREDECODE_EN
        take_jump = in_run && !stall && !redirect_valid &&
                    (instr[OPC_HI:OPC_LO] == OPC_J);
`endif
        if (reset) begin
            next_pc = RESET_PC;
        end else if (redirect_valid) begin
            next_pc = redirect_pc;
        end else if (stall) begin
            next_pc = pc;
        end else if (take_jump) begin
            next_pc = instr[PC_W-1:0];
        end else begin
            next_pc = pc_plus1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and fills IF/ID.
// Define FETCH_JUMP_PREDECODE_EN to let fetch follow J instructions itself.
module fetch_stage #(
    parameter int              PC_W     = risc_pkg::PC_W,
    parameter int              INSTR_W  = risc_pkg::INSTR_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [PC_W-1:0]    ifid_pc_plus1,
    output logic               ifid_valid,
    output logic               ifid_pred
);
    import risc_pkg::*;

    fetch_state_e    state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_plus1;
    logic [PC_W-1:0] next_pc;
    logic            take_jump;
    logic            in_run;

    assign pc_plus1  = pc + PC_W'(1);
    assign imem_addr = pc;
    assign in_run    = (state == RUN);

    fetch_next_pc #(
        .PC_W     (PC_W),
        .INSTR_W  (INSTR_W),
        .RESET_PC (RESET_PC)
    ) u_next_pc (
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .in_run         (in_run),
        .instr          (imem_rdata),
        .pc             (pc),
        .pc_plus1       (pc_plus1),
        .next_pc        (next_pc),
        .take_jump      (take_jump)
    );

    // The PC follows the next-PC select in every case; IF/ID is flushed on
    // redirect, frozen on stall, and otherwise captures the current fetch.
    always_ff @(posedge clk) begin
        pc <= next_pc;
        if (reset) begin
            state         <= RESET_HOLD;
            ifid_instr    <= INSTR_W'(NOP);
            ifid_pc_plus1 <= '0;
            ifid_valid    <= 1'b0;
            ifid_pred     <= 1'b0;
        end else begin
            state <= RUN;
            if (redirect_valid) begin
                ifid_instr <= INSTR_W'(NOP);
                ifid_valid <= 1'b0;
                ifid_pred  <= 1'b0;
            end else if (!stall) begin
                ifid_instr    <= imem_rdata;
                ifid_pc_plus1 <= pc_plus1;
                ifid_valid    <= 1'b1;
                ifid_pred     <= take_jump;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed stimulus pushes expected IF/ID
// contents, a negedge monitor pops and compares whenever ifid_valid is high.
module tb_fetch_stage;

    typedef struct packed {
        logic [31:0] instr;
        logic [4:0]  pp1;
        logic        pred;
    } exp_t;

`ifdef FETCH_JUMP_PREDECODE_EN
    localparam logic PRED_ON = 1'b1;
`else
    localparam logic PRED_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [4:0]  redirect_pc;
    logic [4:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] ifid_instr;
    logic [4:0]  ifid_pc_plus1;
    logic        ifid_valid;
    logic        ifid_pred;

    logic [31:0] mem [32];
    exp_t        exp_q [$];
    exp_t        exp_e;
    int          checks   = 0;
    int          failures = 0;
    logic        done     = 1'b0;

    fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .ifid_instr     (ifid_instr),
        .ifid_pc_plus1  (ifid_pc_plus1),
        .ifid_valid     (ifid_valid),
        .ifid_pred      (ifid_pred)
    );

    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, queue the IF/ID content expected after the
    // edge, then check the address and valid flag just after the edge.
    task automatic applyStimulus(input string name, input logic s, input logic r,
                                 input logic [4:0] rpc, input logic exp_valid,
                                 input logic [31:0] ei, input logic [4:0] epp,
                                 input logic ep, input logic [4:0] eaddr);
        exp_t e;
        stall          = s;
        redirect_valid = r;
        redirect_pc    = rpc;
        if (exp_valid) begin
            e.instr = ei;
            e.pp1   = epp;
            e.pred  = ep;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        checkOutput({name, " imem_addr"}, 32'(imem_addr), 32'(eaddr));
        checkOutput({name, " ifid_valid"}, 32'(ifid_valid), 32'(exp_valid));
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
    endtask

    always @(negedge clk) begin
        if (!done && ifid_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected valid", 32'(ifid_valid), 32'd0);
            end else begin
                exp_e = exp_q.pop_front();
                checkOutput("ifid_instr", ifid_instr, exp_e.instr);
                checkOutput("ifid_pc_plus1", 32'(ifid_pc_plus1), 32'(exp_e.pp1));
                checkOutput("ifid_pred", 32'(ifid_pred), 32'(exp_e.pred));
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'hA500_0000 | 32'(i);
        mem[0] = 32'h0062_2020;
        mem[1] = 32'h8C45_0BB8;
        mem[2] = 32'h1009_000A;
        mem[4] = 32'h0800_000A;

        reset          = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset imem_addr", 32'(imem_addr), 32'd0);
        checkOutput("reset ifid_valid", 32'(ifid_valid), 32'd0);
        checkOutput("reset ifid_instr", ifid_instr, 32'd0);
        checkOutput("reset ifid_pc_plus1", 32'(ifid_pc_plus1), 32'd0);
        checkOutput("reset ifid_pred", 32'(ifid_pred), 32'd0);
        reset = 1'b0;

        applyStimulus("seq0", 0, 0, 0, 1, 32'h0062_2020, 5'd1, 0, 5'd1);
        applyStimulus("seq1", 0, 0, 0, 1, 32'h8C45_0BB8, 5'd2, 0, 5'd2);
        for (int i = 0; i < 3; i++)
            applyStimulus("stall", 1, 0, 0, 1, 32'h8C45_0BB8, 5'd2, 0, 5'd2);
        applyStimulus("release", 0, 0, 0, 1, 32'h1009_000A, 5'd3, 0, 5'd3);
        applyStimulus("seq3", 0, 0, 0, 1, 32'hA500_0003, 5'd4, 0, 5'd4);
        applyStimulus("jfetch", 0, 0, 0, 1, 32'h0800_000A, 5'd5, PRED_ON,
                      PRED_ON ? 5'd10 : 5'd5);
        applyStimulus("redir_stall", 1, 1, 5'd10, 0, '0, '0, 0, 5'd10);
        applyStimulus("target10", 0, 0, 0, 1, 32'hA500_000A, 5'd11, 0, 5'd11);
        applyStimulus("redir30", 0, 1, 5'd30, 0, '0, '0, 0, 5'd30);
        applyStimulus("seq30", 0, 0, 0, 1, 32'hA500_001E, 5'd31, 0, 5'd31);
        applyStimulus("wrap31", 0, 0, 0, 1, 32'hA500_001F, 5'd0, 0, 5'd0);
        applyStimulus("redir4", 0, 1, 5'd4, 0, '0, '0, 0, 5'd4);
        applyStimulus("stall_on_j", 1, 0, 0, 0, '0, '0, 0, 5'd4);
        applyStimulus("redir_on_j", 0, 1, 5'd20, 0, '0, '0, 0, 5'd20);
        applyStimulus("target20", 0, 0, 0, 1, 32'hA500_0014, 5'd21, 0, 5'd21);

        reset          = 1'b1;
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 5'd7;
        @(posedge clk);
        #1;
        checkOutput("midreset imem_addr", 32'(imem_addr), 32'd0);
        checkOutput("midreset ifid_valid", 32'(ifid_valid), 32'd0);
        reset          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        applyStimulus("post_reset", 0, 0, 0, 1, 32'h0062_2020, 5'd1, 0, 5'd1);

        @(negedge clk);
        #1;
        done = 1'b1;
        checkOutput("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
